pwm_cfg_spi_master: RTL and testbench

SPI master that configures the 3-channel PWM peripheral over its SPI slave port. It accepts typed configuration commands (enable, duty cycle, frequency, no-op/readback) on a valid/ready interface. Each command is encoded into the 32-bit header/payload word the slave-side decoder expects and shifted out MSB-first in any of the four CPOL/CPHA modes. The word clocked back on miso is returned to the requester.

---
 rtl/pwm_cfg_spi_master_if.sv | 20 ++
 rtl/pwm_cfg_spi_master.sv | 187 ++++++++++++++++++
 tb/tb_pwm_cfg_spi_master.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pwm_cfg_spi_master_if.sv
// Command/readback channel of the PWM configuration SPI master.
// The requester uses the master modport; the SPI engine uses the slave modport.
interface pwm_cfg_spi_master_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_type;
  logic [29:0] cmd_data;
  logic [31:0] rx_data;
  logic        rx_valid;

  modport master (
    output cmd_valid, cmd_type, cmd_data,
    input  cmd_ready, rx_data, rx_valid
  );

  modport slave (
    input  cmd_valid, cmd_type, cmd_data,
    output cmd_ready, rx_data, rx_valid
  );
endinterface

// File: rtl/pwm_cfg_spi_master.sv
// SPI master that encodes PWM configuration commands into 32-bit words and
// shifts them out MSB-first in any CPOL/CPHA mode, returning the miso word.
module pwm_cfg_spi_master #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       cpol,
  input  logic                       cpha,
  pwm_cfg_spi_master_if.slave        cmd_if,
  output logic                       sclk,
  output logic                       ss_n,
  output logic                       mosi,
  input  logic                       miso,
  output logic                       busy
);

  typedef enum logic [2:0] {IDLE, SETUP, XFER, HOLD, GAP} state_e;

  localparam logic [7:0] DIV_LAST  = 8'(CLK_DIV - 1);
  localparam logic [6:0] EDGE_LAST = 7'd64;

  state_e      state_q, state_d;
  logic [7:0]  div_cnt_q, div_cnt_d;
  logic [6:0]  edge_cnt_q, edge_cnt_d;
  logic [31:0] tx_q, tx_d;
  logic [31:0] rx_sh_q, rx_sh_d;
  logic [31:0] rx_data_q, rx_data_d;
  logic        cpol_q, cpol_d;
  logic        cpha_q, cpha_d;
  logic        sclk_q, sclk_d;
  logic        ss_n_q, ss_n_d;
  logic        mosi_q, mosi_d;
  logic        rx_valid_q, rx_valid_d;
  logic        busy_q, busy_d;
  logic        cmd_ready_q, cmd_ready_d;

  logic        div_wrap;
  logic        accept;
  logic        lead_edge;
  logic        sample_edge;
  logic        drive_edge;
  logic [31:0] cmd_word;

  always_comb begin
    cmd_word = '0;
    unique case (cmd_if.cmd_type)
      2'b00:   cmd_word = {31'b0, cmd_if.cmd_data[0]};
      2'b01:   cmd_word = {2'b01, 6'b0, cmd_if.cmd_data[23:0]};
      2'b10:   cmd_word = {2'b10, cmd_if.cmd_data};
      default: cmd_word = {2'b11, cmd_if.cmd_data};
    endcase
  end

  assign div_wrap    = (div_cnt_q == DIV_LAST);
  assign accept      = (state_q == IDLE) && cmd_if.cmd_valid && cmd_ready_q;
  // edge_cnt_q counts edges already made, so the upcoming edge is odd (leading) when it is even
  assign lead_edge   = ~edge_cnt_q[0];
  assign sample_edge = lead_edge ^ cpha_q;
  assign drive_edge  = cpha_q ? lead_edge : (!lead_edge && (edge_cnt_q < 7'd62));

  always_comb begin
    state_d    = state_q;
    div_cnt_d  = div_cnt_q;
    edge_cnt_d = edge_cnt_q;
    tx_d       = tx_q;
    rx_sh_d    = rx_sh_q;
    rx_data_d  = rx_data_q;
    cpol_d     = cpol_q;
    cpha_d     = cpha_q;
    sclk_d     = sclk_q;
    ss_n_d     = ss_n_q;
    mosi_d     = mosi_q;
    rx_valid_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        sclk_d = cpol;
        ss_n_d = 1'b1;
        mosi_d = 1'b0;
        if (accept) begin
          state_d    = SETUP;
          div_cnt_d  = '0;
          edge_cnt_d = '0;
          rx_sh_d    = '0;
          cpol_d     = cpol;
          cpha_d     = cpha;
          ss_n_d     = 1'b0;
          // in phase 0 bit 31 is presented before the first edge
          if (cpha) begin
            mosi_d = 1'b0;
            tx_d   = cmd_word;
          end else begin
            mosi_d = cmd_word[31];
            tx_d   = {cmd_word[30:0], 1'b0};
          end
        end
      end

      SETUP, XFER: begin
        div_cnt_d = div_wrap ? '0 : div_cnt_q + 8'd1;
        if (div_wrap) begin
          if (edge_cnt_q == EDGE_LAST) begin
            state_d = HOLD;
          end else begin
            state_d    = XFER;
            edge_cnt_d = edge_cnt_q + 7'd1;
            sclk_d     = ~sclk_q;
            if (sample_edge) begin
              rx_sh_d = {rx_sh_q[30:0], miso};
            end else if (drive_edge) begin
              mosi_d = tx_q[31];
              tx_d   = {tx_q[30:0], 1'b0};
            end
          end
        end
      end

      HOLD: begin
        div_cnt_d = div_wrap ? '0 : div_cnt_q + 8'd1;
        if (div_wrap) begin
          state_d    = GAP;
          ss_n_d     = 1'b1;
          mosi_d     = 1'b0;
          rx_data_d  = rx_sh_q;
          rx_valid_d = 1'b1;
        end
      end

      GAP: begin
        div_cnt_d = div_wrap ? '0 : div_cnt_q + 8'd1;
        if (div_wrap) begin
          state_d = IDLE;
          sclk_d  = cpol;
        end
      end

      default: state_d = IDLE;
    endcase

    busy_d      = (state_d != IDLE);
    cmd_ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      div_cnt_q   <= '0;
      edge_cnt_q  <= '0;
      tx_q        <= '0;
      rx_sh_q     <= '0;
      rx_data_q   <= '0;
      cpol_q      <= 1'b0;
      cpha_q      <= 1'b0;
      sclk_q      <= cpol;
      ss_n_q      <= 1'b1;
      mosi_q      <= 1'b0;
      rx_valid_q  <= 1'b0;
      busy_q      <= 1'b0;
      cmd_ready_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      div_cnt_q   <= div_cnt_d;
      edge_cnt_q  <= edge_cnt_d;
      tx_q        <= tx_d;
      rx_sh_q     <= rx_sh_d;
      rx_data_q   <= rx_data_d;
      cpol_q      <= cpol_d;
      cpha_q      <= cpha_d;
      sclk_q      <= sclk_d;
      ss_n_q      <= ss_n_d;
      mosi_q      <= mosi_d;
      rx_valid_q  <= rx_valid_d;
      busy_q      <= busy_d;
      cmd_ready_q <= cmd_ready_d;
    end
  end

  assign sclk             = sclk_q;
  assign ss_n             = ss_n_q;
  assign mosi             = mosi_q;
  assign busy             = busy_q;
  assign cmd_if.cmd_ready = cmd_ready_q;
  assign cmd_if.rx_data   = rx_data_q;
  assign cmd_if.rx_valid  = rx_valid_q;

endmodule

// File: tb/tb_pwm_cfg_spi_master.sv
// Bench for pwm_cfg_spi_master: timeline model of the transaction, a
// behavioural SPI slave, directed cases and randomized commands.
module tb_pwm_cfg_spi_master;

  localparam int D = 4;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic cpol = 1'b0;
  logic cpha = 1'b0;
  logic miso = 1'b0;
  logic sclk, ss_n, mosi, busy;

  pwm_cfg_spi_master_if bus ();

  pwm_cfg_spi_master #(.CLK_DIV(D)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .cpol    (cpol),
    .cpha    (cpha),
    .cmd_if  (bus),
    .sclk    (sclk),
    .ss_n    (ss_n),
    .mosi    (mosi),
    .miso    (miso),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @cyc %0d: got %h, want %h", nm, cyc, act, exp);
    end
  endtask

  function automatic logic [31:0] enc(input logic [1:0] t, input logic [29:0] d);
    case (t)
      2'b00:   enc = {31'b0, d[0]};
      2'b01:   enc = {8'h40, d[23:0]};
      2'b10:   enc = {2'b10, d};
      default: enc = {2'b11, d};
    endcase
  endfunction

  // ---------------- behavioural SPI slave ----------------
  logic [31:0] slv_word = '0;
  logic        slv_cpha = 1'b0;
  logic [31:0] slv_done_word = '0;
  int          slv_done_bits = 0;
  int          slv_done_edges = 0;

  initial begin : slave
    logic [31:0] sh, rx;
    logic        idle, ph, lead;
    int          bits, edges;
    forever begin
      @(negedge ss_n);
      idle = sclk; ph = slv_cpha; sh = slv_word; rx = '0; bits = 0; edges = 0;
      if (!ph) begin miso = sh[31]; sh = sh << 1; end
      while (ss_n === 1'b0) begin
        @(sclk or ss_n);
        if (ss_n !== 1'b0) break;
        edges++;
        lead = (sclk !== idle);
        if (lead ^ ph) begin
          rx = {rx[30:0], mosi};
          bits++;
        end else begin
          miso = sh[31];
          sh = sh << 1;
        end
      end
      slv_done_word = rx; slv_done_bits = bits; slv_done_edges = edges;
    end
  end

  // ---------------- model + per-cycle compare ----------------
  logic        m_txn = 1'b0, m_ready = 1'b0, m_rxv = 1'b0;
  logic        m_cpol = 1'b0, m_cpha = 1'b0, m_cpol_in = 1'b0;
  logic [31:0] m_word = '0, m_srx = '0, m_rx = '0;
  int          m_t0 = 0;

  initial begin : compare
    int r, n, j, k;
    forever begin
      @(posedge clk);
      cyc++;
      m_cpol_in = cpol;
      if (reset_n !== 1'b1) begin
        m_txn = 1'b0; m_ready = 1'b0; m_rxv = 1'b0; m_rx = '0;
      end else begin
        m_rxv = 1'b0;
        if (m_txn) begin
          r = cyc - m_t0;
          if (r == 66 * D) begin m_rxv = 1'b1; m_rx = m_srx; end
          if (r == 67 * D) begin m_txn = 1'b0; m_ready = 1'b1; end
        end else if (bus.cmd_valid === 1'b1 && m_ready) begin
          m_txn = 1'b1; m_t0 = cyc; m_ready = 1'b0;
          m_word = enc(bus.cmd_type, bus.cmd_data);
          m_cpol = cpol; m_cpha = cpha; m_srx = slv_word;
        end else begin
          m_ready = 1'b1;
        end
      end

      @(negedge clk);
      r = m_txn ? (cyc - m_t0) : 0;
      n = r / D;
      if (n > 64) n = 64;
      chk("busy", busy, m_txn);
      chk("cmd_ready", bus.cmd_ready, m_ready);
      chk("rx_valid", bus.rx_valid, m_rxv);
      chk("rx_data", bus.rx_data, m_rx);
      chk("ss_n", ss_n, (m_txn && r < 66 * D) ? 1'b0 : 1'b1);
      if (!m_txn) begin
        chk("sclk_idle", sclk, m_cpol_in);
        chk("mosi_idle", mosi, 1'b0);
      end else if (r < 66 * D) begin
        chk("sclk", sclk, m_cpol ^ n[0]);
        if (!m_cpha) begin
          j = n / 2;
          if (j > 31) j = 31;
          chk("mosi", mosi, m_word[31 - j]);
        end else begin
          k = (n + 1) / 2;
          if (k > 0) chk("mosi", mosi, m_word[32 - k]);
        end
      end else begin
        chk("sclk_gap", sclk, m_cpol);
      end
      if (m_txn && r == 66 * D) begin
        chk("slave_word", slv_done_word, m_word);
        chk("slave_bits", slv_done_bits, 32);
        chk("slave_edges", slv_done_edges, 64);
      end
    end
  end

  // ---------------- event counters ----------------
  int sslow_n = 0, rxv_n = 0, rise_n = 0, last_rise = 0, prev_rise = 0;
  logic busy_prev = 1'b0;

  initial begin : monitor
    forever begin
      @(negedge clk);
      if (ss_n === 1'b0) sslow_n++;
      if (bus.rx_valid === 1'b1) rxv_n++;
      if (busy === 1'b1 && busy_prev !== 1'b1) begin
        prev_rise = last_rise; last_rise = cyc; rise_n++;
      end
      busy_prev = busy;
    end
  end

  // ---------------- stimulus ----------------
  task automatic wait_idle();
    bit ok = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (busy === 1'b0 && bus.cmd_ready === 1'b1) begin ok = 1; break; end
    end
    chk("idle_timeout", ok, 1);
  endtask

  task automatic send(input logic [1:0] t, input logic [29:0] d, input logic p,
                      input logic h, input logic [31:0] sw, input bit wait_done);
    bit ok = 0;
    @(posedge clk); #1;
    cpol = p; cpha = h; slv_cpha = h; slv_word = sw;
    repeat (2) @(posedge clk);
    #1;
    bus.cmd_type = t; bus.cmd_data = d; bus.cmd_valid = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      @(posedge clk);
      if (bus.cmd_ready === 1'b1) begin ok = 1; break; end
    end
    #1 bus.cmd_valid = 1'b0;
    chk("accept_timeout", ok, 1);
    if (wait_done) wait_idle();
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int s0, v0, r0;
    bus.cmd_valid = 1'b0; bus.cmd_type = 2'b00; bus.cmd_data = '0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ss_n", ss_n, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_ready", bus.cmd_ready, 1'b0);
    chk("rst_rx_valid", bus.rx_valid, 1'b0);
    chk("rst_rx_data", bus.rx_data, 32'h0);
    chk("rst_mosi", mosi, 1'b0);
    chk("rst_sclk", sclk, 1'b0);
    @(posedge clk); #1 reset_n = 1'b1;
    @(negedge clk);
    chk("ready_first", bus.cmd_ready, 1'b0);
    @(negedge clk);
    chk("ready_after_reset", bus.cmd_ready, 1'b1);

    // mode 0 duty command
    s0 = sslow_n; v0 = rxv_n;
    send(2'b01, 30'h00ABCDEF, 1'b0, 1'b0, 32'h1234_5678, 1);
    chk("m0_slave_word", slv_done_word, 32'h40AB_CDEF);
    chk("m0_slave_bits", slv_done_bits, 32);
    chk("m0_ss_low_cycles", sslow_n - s0, 264);
    chk("m0_rx_pulses", rxv_n - v0, 1);

    // mode 3 frequency command
    @(posedge clk); #1 cpol = 1'b1;
    repeat (2) @(negedge clk);
    chk("m3_sclk_idle_high", sclk, 1'b1);
    send(2'b10, 30'h3FFF_FFFF, 1'b1, 1'b1, 32'h0F0F_0F0F, 1);
    chk("m3_slave_word", slv_done_word, 32'hBFFF_FFFF);

    // readback in all four modes
    for (int m = 0; m < 4; m++) begin
      v0 = rxv_n;
      send(2'b11, 30'($urandom), m[1], m[0], 32'hA5A5_A5A5, 1);
      chk("rb_rx_data", bus.rx_data, 32'hA5A5_A5A5);
      chk("rb_rx_pulses", rxv_n - v0, 1);
    end

    // enable command masks upper payload
    send(2'b00, 30'h3FFF_FFFF, 1'b0, 1'b1, 32'h0000_0003, 1);
    chk("en_slave_word", slv_done_word, 32'h0000_0001);

    // back-to-back with cmd_valid held, cpol toggled mid-transfer
    @(posedge clk); #1;
    cpol = 1'b0; cpha = 1'b0; slv_cpha = 1'b0; slv_word = 32'h3C3C_C3C3;
    repeat (2) @(posedge clk);
    #1;
    r0 = rise_n;
    bus.cmd_type = 2'b10; bus.cmd_data = 30'h1555_AAAA; bus.cmd_valid = 1'b1;
    for (int i = 0; i < 50 && rise_n == r0; i++) @(posedge clk);
    repeat (50) @(posedge clk);
    #1 cpol = 1'b1; slv_word = 32'h9696_6969;
    for (int i = 0; i < 600 && rise_n < r0 + 2; i++) @(posedge clk);
    #1 bus.cmd_valid = 1'b0;
    chk("b2b_accepts", rise_n - r0, 2);
    chk("b2b_interval", last_rise - prev_rise, 269);
    wait_idle();

    // reset 30 cycles into a transfer
    send(2'b01, 30'h0012_3456, 1'b0, 1'b0, 32'hDEAD_BEEF, 0);
    repeat (29) @(posedge clk);
    #1 reset_n = 1'b0;
    @(posedge clk); #1 reset_n = 1'b1;
    v0 = rxv_n;
    @(negedge clk);
    chk("rstmid_ss_n", ss_n, 1'b1);
    chk("rstmid_busy", busy, 1'b0);
    chk("rstmid_rx_data", bus.rx_data, 32'h0);
    chk("rstmid_rx_valid", bus.rx_valid, 1'b0);
    repeat (2) @(negedge clk);
    send(2'b10, 30'h2468_ACE0, 1'b1, 1'b0, 32'h5566_7788, 1);
    chk("rstmid_after_rx", bus.rx_data, 32'h5566_7788);
    chk("rstmid_after_pulses", rxv_n - v0, 1);

    // randomized commands with ignored mid-transfer traffic
    for (int it = 0; it < 12; it++) begin
      send(2'($urandom), 30'($urandom), 1'($urandom), 1'($urandom), $urandom, 0);
      repeat ($urandom_range(5, 100)) @(posedge clk);
      #1;
      bus.cmd_valid = 1'b1; bus.cmd_type = 2'($urandom); bus.cmd_data = 30'($urandom);
      cpol = 1'($urandom); cpha = 1'($urandom);
      repeat ($urandom_range(1, 20)) @(posedge clk);
      #1 bus.cmd_valid = 1'b0;
      wait_idle();
      repeat ($urandom_range(0, 4)) @(posedge clk);
    end

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
